mac_scheduler: RTL and testbench

- Time-shares one 25x18 multiplier/48-bit accumulator among NREQ filter stages (halfband 1, halfband 2, compensation FIR) in the decimation chain.
- Each stage streams its (coefficient, sample) tap pairs as a burst. The scheduler grants bursts round-robin, accumulates them, and returns one tagged 48-bit sum per burst.
- Replaces per-tap result registers and FIFO tagging with a single sequenced MAC datapath on MACCLK.

---
 rtl/mac_sched_pkg.sv | 17 +
 rtl/mac_scheduler_if.sv | 29 ++
 rtl/mac_scheduler_rr_arbiter.sv | 26 ++
 rtl/mac_scheduler.sv | 165 ++++++++++++++++
 tb/tb_mac_scheduler.sv | 346 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mac_sched_pkg.sv
// Shared widths, FSM state type and accumulator limits for the time-shared MAC scheduler.
package mac_sched_pkg;

    localparam int A_W   = 25;
    localparam int B_W   = 18;
    localparam int P_W   = 43;
    localparam int ACC_W = 48;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    localparam logic signed [ACC_W-1:0] ACC_MAX = 48'sh7FFF_FFFF_FFFF;
    localparam logic signed [ACC_W-1:0] ACC_MIN = 48'sh8000_0000_0000;

endpackage

// File: rtl/mac_scheduler_if.sv
// Request/result bus between the filter stages (master) and the MAC scheduler (slave).
interface mac_scheduler_if #(
    parameter int NREQ  = 3,
    parameter int TAG_W = 2
);
    import mac_sched_pkg::*;

    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*A_W-1:0]   req_a;
    logic [NREQ*B_W-1:0]   req_b;
    logic [NREQ-1:0]       req_last;
    logic                  res_valid;
    logic [TAG_W-1:0]      res_tag;
    logic [ACC_W-1:0]      res_data;
    logic                  busy;
    logic                  burst_err;

    modport master (
        output req_valid, req_a, req_b, req_last,
        input  req_ready, res_valid, res_tag, res_data, busy, burst_err
    );

    modport slave (
        input  req_valid, req_a, req_b, req_last,
        output req_ready, res_valid, res_tag, res_data, busy, burst_err
    );

endinterface

// File: rtl/mac_scheduler_rr_arbiter.sv
// Combinational round-robin search: first set request at or after ptr, modulo NREQ.
module rr_arbiter #(
    parameter int NREQ  = 3,
    parameter int TAG_W = 2
) (
    input  logic [NREQ-1:0]  req,
    input  logic [TAG_W-1:0] ptr,
    output logic [TAG_W-1:0] grant,
    output logic             any_req
);

    int idx;

    // Scan from the farthest offset down so the closest requester to ptr wins.
    always_comb begin
        grant   = '0;
        any_req = |req;
        idx     = 0;
        for (int off = NREQ - 1; off >= 0; off--) begin
            idx = int'(ptr) + off;
            if (idx >= NREQ) idx = idx - NREQ;
            if (req[idx]) grant = TAG_W'(idx);
        end
    end

endmodule

// File: rtl/mac_scheduler.sv
// Round-robin burst scheduler feeding one shared 25x18 MAC with a 48-bit accumulator.
// Define MAC_SCHEDULER_SAT_EN to saturate the accumulator instead of wrapping.
module mac_scheduler
    import mac_sched_pkg::*;
#(
    parameter int NREQ     = 3,
    parameter int MAX_TAPS = 64,
    parameter int TAG_W    = 2
) (
    input logic            MACCLK,
    input logic            RSTN,
    mac_scheduler_if.slave bus
);

    localparam int CNT_W = (MAX_TAPS > 1) ? $clog2(MAX_TAPS) : 1;

    function automatic logic [TAG_W-1:0] next_ptr(input logic [TAG_W-1:0] g);
        return (int'(g) == NREQ - 1) ? '0 : g + TAG_W'(1);
    endfunction

    function automatic logic signed [ACC_W-1:0] acc_step(
        input logic signed [ACC_W-1:0] acc,
        input logic signed [P_W-1:0]   p
    );
        logic signed [ACC_W:0] sum;
        sum = $signed({acc[ACC_W-1], acc}) + $signed({{(ACC_W + 1 - P_W){p[P_W-1]}}, p});
`ifdef MAC_SCHEDULER_SAT_EN
        if (sum[ACC_W] != sum[ACC_W-1]) return sum[ACC_W] ? ACC_MIN : ACC_MAX;
`endif
        return $signed(sum[ACC_W-1:0]);
    endfunction

    state_t            state_q;
    logic [TAG_W-1:0]  grant_q;
    logic [TAG_W-1:0]  ptr_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [NREQ-1:0]   ready_q;
    logic              err_q;

    logic [TAG_W-1:0]  arb_idx;
    logic              arb_any;

    logic signed [A_W-1:0] a_sel;
    logic signed [B_W-1:0] b_sel;
    logic                  last_sel;
    logic                  accept;
    logic                  max_hit;
    logic                  burst_end;

    logic                  vld_p1;
    logic signed [A_W-1:0] a_p1;
    logic signed [B_W-1:0] b_p1;
    logic                  first_p1;
    logic                  last_p1;
    logic [TAG_W-1:0]      tag_p1;
    logic signed [P_W-1:0] prod_p1;

    logic signed [ACC_W-1:0] acc_p2;
    logic                    res_vld_p2;
    logic [TAG_W-1:0]        tag_p2;

    rr_arbiter #(
        .NREQ  (NREQ),
        .TAG_W (TAG_W)
    ) u_arb (
        .req     (bus.req_valid),
        .ptr     (ptr_q),
        .grant   (arb_idx),
        .any_req (arb_any)
    );

    always_comb begin
        a_sel     = $signed(bus.req_a[int'(grant_q) * A_W +: A_W]);
        b_sel     = $signed(bus.req_b[int'(grant_q) * B_W +: B_W]);
        last_sel  = bus.req_last[grant_q];
        accept    = bus.req_valid[grant_q] & ready_q[grant_q];
        max_hit   = (cnt_q == CNT_W'(MAX_TAPS - 1));
        burst_end = accept & (last_sel | max_hit);
    end

    // Control: arbitration in IDLE, beat counting and burst termination in BURST.
    always_ff @(posedge MACCLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            ready_q <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    ready_q <= '0;
                    if (arb_any) begin
                        grant_q <= arb_idx;
                        cnt_q   <= '0;
                        ready_q <= NREQ'(1) << arb_idx;
                        state_q <= BURST;
                    end
                end
                BURST: begin
                    if (accept) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (burst_end) begin
                            state_q <= IDLE;
                            ready_q <= '0;
                            ptr_q   <= next_ptr(grant_q);
                            if (max_hit && !last_sel) err_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= '0;
                end
            endcase
        end
    end

    // Stage 1: capture the accepted beat and its burst markers.
    always_ff @(posedge MACCLK or negedge RSTN) begin
        if (!RSTN) begin
            vld_p1   <= 1'b0;
            a_p1     <= '0;
            b_p1     <= '0;
            first_p1 <= 1'b0;
            last_p1  <= 1'b0;
            tag_p1   <= '0;
        end else begin
            vld_p1 <= accept;
            if (accept) begin
                a_p1     <= a_sel;
                b_p1     <= b_sel;
                first_p1 <= (cnt_q == '0);
                last_p1  <= burst_end;
                tag_p1   <= grant_q;
            end
        end
    end

    always_comb prod_p1 = a_p1 * b_p1;

    // Stage 2: accumulate; the first flag restarts the sum so bursts never mix.
    always_ff @(posedge MACCLK or negedge RSTN) begin
        if (!RSTN) begin
            acc_p2     <= '0;
            res_vld_p2 <= 1'b0;
            tag_p2     <= '0;
        end else begin
            res_vld_p2 <= vld_p1 & last_p1;
            if (vld_p1) begin
                acc_p2 <= acc_step(first_p1 ? '0 : acc_p2, prod_p1);
                tag_p2 <= tag_p1;
            end
        end
    end

    assign bus.req_ready = ready_q;
    assign bus.res_valid = res_vld_p2;
    assign bus.res_tag   = tag_p2;
    assign bus.res_data  = acc_p2;
    assign bus.busy      = (state_q == BURST) | vld_p1;
    assign bus.burst_err = err_q;

endmodule

// File: tb/tb_mac_scheduler.sv
// Bench for mac_scheduler: two instances (MAX_TAPS 512 and 4) share one stimulus stream.
module tb_mac_scheduler;
    import mac_sched_pkg::*;

    localparam int NREQ  = 3;
    localparam int TAG_W = 2;

    logic MACCLK = 1'b0;
    logic RSTN   = 1'b0;
    always #5 MACCLK = ~MACCLK;

    mac_scheduler_if #(.NREQ(NREQ), .TAG_W(TAG_W)) ifm ();
    mac_scheduler_if #(.NREQ(NREQ), .TAG_W(TAG_W)) ift ();

    mac_scheduler #(.NREQ(NREQ), .MAX_TAPS(512), .TAG_W(TAG_W)) dut (
        .MACCLK (MACCLK), .RSTN (RSTN), .bus (ifm));
    mac_scheduler #(.NREQ(NREQ), .MAX_TAPS(4), .TAG_W(TAG_W)) dut_t (
        .MACCLK (MACCLK), .RSTN (RSTN), .bus (ift));

    logic        v_d [NREQ];
    logic        l_d [NREQ];
    logic [24:0] a_d [NREQ];
    logic [17:0] b_d [NREQ];

    logic [NREQ-1:0]    v_pk, l_pk, rdy_sel;
    logic [NREQ*25-1:0] a_pk;
    logic [NREQ*18-1:0] b_pk;
    int sel = 0;

    always_comb begin
        v_pk = '0; l_pk = '0; a_pk = '0; b_pk = '0;
        for (int i = 0; i < NREQ; i++) begin
            v_pk[i] = v_d[i];
            l_pk[i] = l_d[i];
            a_pk[25*i +: 25] = a_d[i];
            b_pk[18*i +: 18] = b_d[i];
        end
        rdy_sel = (sel == 1) ? ift.req_ready : ifm.req_ready;
    end

    assign ifm.req_valid = v_pk;  assign ift.req_valid = v_pk;
    assign ifm.req_last  = l_pk;  assign ift.req_last  = l_pk;
    assign ifm.req_a     = a_pk;  assign ift.req_a     = a_pk;
    assign ifm.req_b     = b_pk;  assign ift.req_b     = b_pk;

    int n_vec = 0;
    int n_err = 0;
    bit abort = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Reference model: each burst is the plain sum of a*b over its accepted beats.
    typedef struct {int tag; logic [47:0] data; bit err; int due;} exp_t;
    typedef struct {int tag; logic [47:0] data; bit err;} res_t;

    exp_t   expq [2][$];
    res_t   logq [2][$];
    int     owner [2];
    int     cnt   [2];
    longint acc   [2];
    bit     sticky[2];
    int     cyc = 0;

    function automatic longint wrap48(input longint v);
        logic [47:0] t;
        t = v[47:0];
        return longint'($signed(t));
    endfunction

    function automatic longint step(input longint s0, input longint p);
        longint s;
        s = s0 + p;
`ifdef MAC_SCHEDULER_SAT_EN
        if (s > 64'sd140737488355327) s = 64'sd140737488355327;
        else if (s < -64'sd140737488355328) s = -64'sd140737488355328;
        return s;
`else
        return wrap48(s);
`endif
    endfunction

    task automatic mon(input int id, input logic [NREQ-1:0] rdy, input logic rv,
                       input logic [TAG_W-1:0] rt, input logic [47:0] rd, input logic be);
        exp_t e;
        res_t r;
        longint p, t;
        int maxt;
        maxt = (id == 1) ? 4 : 512;
        chk($sformatf("ready_onehot dut%0d", id), 64'($countones(rdy) <= 1), 64'd1);
        while (expq[id].size() > 0 && expq[id][0].due < cyc) begin
            n_vec++; n_err++;
            $display("FAIL res_missing dut%0d: no res_valid, expected tag %0d data %0h at cycle %0d",
                     id, expq[id][0].tag, expq[id][0].data, expq[id][0].due);
            void'(expq[id].pop_front());
        end
        if (rv) begin
            r.tag = int'(rt); r.data = rd; r.err = be;
            logq[id].push_back(r);
            if (expq[id].size() == 0 || expq[id][0].due != cyc) begin
                n_vec++; n_err++;
                $display("FAIL res_unexpected dut%0d: got res_valid tag %0d data %0h, expected none",
                         id, rt, rd);
            end else begin
                e = expq[id].pop_front();
                chk($sformatf("res_tag dut%0d", id), 64'(rt), 64'(e.tag));
                chk($sformatf("res_data dut%0d", id), 64'(rd), 64'(e.data));
                chk($sformatf("burst_err dut%0d", id), 64'(be), 64'(e.err));
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (v_pk[i] && rdy[i]) begin
                if (owner[id] < 0) begin
                    owner[id] = i; cnt[id] = 0; acc[id] = 0;
                end else if (owner[id] != i) begin
                    chk($sformatf("accept_owner dut%0d", id), 64'(i), 64'(owner[id]));
                end
                p = longint'($signed(a_pk[25*i +: 25])) * longint'($signed(b_pk[18*i +: 18]));
                acc[id] = step(acc[id], p);
                cnt[id]++;
                if (l_pk[i] || cnt[id] == maxt) begin
                    if (!l_pk[i]) sticky[id] = 1'b1;
                    t = acc[id];
                    e.tag = owner[id]; e.data = t[47:0]; e.err = sticky[id]; e.due = cyc + 2;
                    expq[id].push_back(e);
                    owner[id] = -1;
                end
            end
        end
    endtask

    always @(negedge MACCLK) begin
        cyc++;
        if (!RSTN) begin
            for (int k = 0; k < 2; k++) begin
                owner[k] = -1; cnt[k] = 0; acc[k] = 0; sticky[k] = 1'b0;
                expq[k].delete();
            end
        end else begin
            mon(0, ifm.req_ready, ifm.res_valid, ifm.res_tag, ifm.res_data, ifm.burst_err);
            mon(1, ift.req_ready, ift.res_valid, ift.res_tag, ift.res_data, ift.burst_err);
        end
    end

    task automatic check_idle_outputs(input string nm);
        chk({nm, " ready dut0"}, 64'(ifm.req_ready), 64'd0);
        chk({nm, " busy dut0"},  64'(ifm.busy), 64'd0);
        chk({nm, " res_valid dut0"}, 64'(ifm.res_valid), 64'd0);
        chk({nm, " ready dut1"}, 64'(ift.req_ready), 64'd0);
        chk({nm, " busy dut1"},  64'(ift.busy), 64'd0);
        chk({nm, " res_valid dut1"}, 64'(ift.res_valid), 64'd0);
    endtask

    task automatic do_reset(input string nm);
        @(posedge MACCLK);
        #3;
        RSTN = 1'b0;
        for (int i = 0; i < NREQ; i++) begin v_d[i] = 1'b0; l_d[i] = 1'b0; end
        #1;
        check_idle_outputs(nm);
        repeat (2) @(negedge MACCLK);
        #1 RSTN = 1'b1;
        @(posedge MACCLK);
        #1;
    endtask

    task automatic wait_accept(input int r);
        int t;
        bit done;
        t = 0; done = 0;
        while (!done && !abort) begin
            @(negedge MACCLK);
            if (rdy_sel[r]) begin
                @(posedge MACCLK);
                #1;
                done = 1;
            end else if (++t > 2000) begin
                n_vec++; n_err++; abort = 1;
                $display("FAIL accept_timeout req%0d: no ready within 2000 cycles", r);
            end
        end
    endtask

    task automatic drive(input int r, input int n, input logic [24:0] a, input logic [17:0] b,
                         input int gap_at, input int gap_len, input bit rnd, input bit no_last);
        for (int k = 0; k < n; k++) begin
            v_d[r] = 1'b1;
            a_d[r] = rnd ? 25'($urandom) : a;
            b_d[r] = rnd ? 18'($urandom) : b;
            l_d[r] = (k == n - 1) && !no_last;
            wait_accept(r);
            if (k == gap_at) begin
                v_d[r] = 1'b0; l_d[r] = 1'b0;
                repeat (gap_len) @(posedge MACCLK);
                #1;
            end
        end
        v_d[r] = 1'b0;
        l_d[r] = 1'b0;
    endtask

    task automatic wait_log(input int id, input int n);
        int t;
        t = 0;
        while (logq[id].size() < n && t < 100) begin
            @(posedge MACCLK);
            t++;
        end
        #1;
        chk($sformatf("result_count dut%0d", id), 64'(logq[id].size()), 64'(n));
    endtask

    task automatic check_res(input string nm, input int id, input int idx,
                             input int tag, input logic [47:0] data, input bit err);
        if (logq[id].size() > idx) begin
            chk({nm, " tag"},  64'(logq[id][idx].tag), 64'(tag));
            chk({nm, " data"}, 64'(logq[id][idx].data), 64'(data));
            chk({nm, " err"},  64'(logq[id][idx].err), 64'(err));
        end
    endtask

    typedef struct {
        int req; int n; logic [24:0] a; logic [17:0] b;
        int gap_at; int gap_len; logic [47:0] exp_data;
    } vec_t;

    initial begin
        vec_t tbl[5];
        int base;
        longint golden;
        logic [47:0] exp_sat;

        tbl[0] = '{0, 3, 25'd2,        18'd3,       -1, 0, 48'd18};
        tbl[1] = '{1, 2, 25'h1FFFFFF,  18'd5,        0, 4, 48'hFFFF_FFFF_FFF6};
        tbl[2] = '{2, 1, 25'h1FFFFFB,  18'd7,       -1, 0, 48'hFFFF_FFFF_FFDD};
        tbl[3] = '{0, 4, 25'h1000000,  18'h20000,   -1, 0, 48'h0800_0000_0000};
        tbl[4] = '{1, 2, 25'h0FFFFFF,  18'h1FFFF,   -1, 0, 48'h03FF_FDFC_0002};

        for (int i = 0; i < NREQ; i++) begin
            v_d[i] = 1'b0; l_d[i] = 1'b0; a_d[i] = '0; b_d[i] = '0;
        end
        #2;
        chk("reset ready",     64'(ifm.req_ready), 64'd0);
        chk("reset res_valid", 64'(ifm.res_valid), 64'd0);
        chk("reset res_tag",   64'(ifm.res_tag),   64'd0);
        chk("reset res_data",  64'(ifm.res_data),  64'd0);
        chk("reset busy",      64'(ifm.busy),      64'd0);
        chk("reset burst_err", 64'(ifm.burst_err), 64'd0);
        do_reset("reset0");

        for (int v = 0; v < 5; v++) begin
            base = logq[0].size();
            drive(tbl[v].req, tbl[v].n, tbl[v].a, tbl[v].b, tbl[v].gap_at, tbl[v].gap_len, 0, 0);
            wait_log(0, base + 1);
            check_res($sformatf("vec%0d", v), 0, base, tbl[v].req, tbl[v].exp_data, 1'b0);
        end

        do_reset("reset_contention");
        base = logq[0].size();
        fork
            begin
                drive(0, 2, 25'd1, 18'd1, -1, 0, 0, 0);
                drive(0, 2, 25'd1, 18'd1, -1, 0, 0, 0);
            end
            drive(1, 2, 25'd1, 18'd2, -1, 0, 0, 0);
            drive(2, 2, 25'd1, 18'd3, -1, 0, 0, 0);
        join
        wait_log(0, base + 4);
        check_res("rr0", 0, base,     0, 48'd2, 1'b0);
        check_res("rr1", 0, base + 1, 1, 48'd4, 1'b0);
        check_res("rr2", 0, base + 2, 2, 48'd6, 1'b0);
        check_res("rr3", 0, base + 3, 0, 48'd2, 1'b0);

        do_reset("reset_trunc");
        sel = 1;
        base = logq[1].size();
        drive(2, 6, 25'd1, 18'd1, -1, 0, 0, 0);
        wait_log(1, base + 2);
        check_res("trunc_a", 1, base,     2, 48'd4, 1'b1);
        check_res("trunc_b", 1, base + 1, 2, 48'd2, 1'b1);
        sel = 0;

        do_reset("reset_pre_mid");
        base = logq[0].size();
        drive(0, 1, 25'd7, 18'd1, -1, 0, 0, 0);
        wait_log(0, base + 1);
        drive(1, 2, 25'd3, 18'd3, -1, 0, 0, 1);
        chk("mid_burst busy", 64'(ifm.busy), 64'd1);
        do_reset("reset_mid");
        base = logq[0].size();
        fork
            drive(0, 1, 25'd3, 18'd4, -1, 0, 0, 0);
            drive(1, 1, 25'd5, 18'd5, -1, 0, 0, 0);
        join
        wait_log(0, base + 2);
        check_res("post_reset0", 0, base,     0, 48'd12, 1'b0);
        check_res("post_reset1", 0, base + 1, 1, 48'd25, 1'b0);

        do_reset("reset_sat");
        base = logq[0].size();
        drive(0, 300, 25'h0FFFFFF, 18'h1FFFF, -1, 0, 0, 0);
        wait_log(0, base + 1);
`ifdef MAC_SCHEDULER_SAT_EN
        exp_sat = 48'h7FFF_FFFF_FFFF;
`else
        golden  = wrap48(longint'(300) * longint'(16777215) * longint'(131071));
        exp_sat = golden[47:0];
`endif
        check_res("saturation", 0, base, 0, exp_sat, 1'b0);

        do_reset("reset_rand");
        fork
            for (int r = 0; r < NREQ; r++) begin
                automatic int rr = r;
                fork
                    for (int k = 0; k < 8; k++) begin
                        automatic int n = $urandom_range(1, 6);
                        drive(rr, n, '0, '0, $urandom_range(0, n), $urandom_range(0, 3), 1, 0);
                        repeat ($urandom_range(0, 2)) @(posedge MACCLK);
                        #1;
                    end
                join_none
            end
        join_none
        wait fork;
        repeat (20) @(posedge MACCLK);
        #1;
        chk("drain dut0", 64'(expq[0].size()), 64'd0);
        chk("drain dut1", 64'(expq[1].size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
